// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of RUN cycles one operation takes.
  function automatic int unsigned calc_steps(int unsigned width, int unsigned bpc);
    return (bpc == 0) ? 1 : width / bpc;
  endfunction

  function automatic bit cfg_valid(int unsigned width, int unsigned bpc);
    return (width >= 1) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational ripple full subtractor over WIDTH bits, LSB first.
module sub_slice #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             br_in,
  output logic [WIDTH-1:0] diff,
  output logic             br_out
);

  logic [WIDTH:0] br;

  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = br_in;
    for (int i = 0; i < int'(WIDTH); i++) begin
      diff[i]  = x[i] ^ y[i] ^ br[i];
      br[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
    br_out = br[WIDTH];
  end

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor D = A - B - Bin, BITS_PER_CYCLE bits per clock, LSB first,
// with valid/ready handshakes on both sides.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int unsigned STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(STEPS - 1);

  if (!cfg_valid(WIDTH, BITS_PER_CYCLE)) begin : gen_bad_cfg
    $error("serial_sub: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              br_q, br_d;
  logic              bout_q, bout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [BITS_PER_CYCLE-1:0]       slice_diff;
  logic                            slice_br;
  logic [WIDTH+BITS_PER_CYCLE-1:0] d_cat;

  sub_slice #(
    .WIDTH (BITS_PER_CYCLE)
  ) u_slice (
    .x      (a_q[BITS_PER_CYCLE-1:0]),
    .y      (b_q[BITS_PER_CYCLE-1:0]),
    .br_in  (br_q),
    .diff   (slice_diff),
    .br_out (slice_br)
  );

  // New slice enters from the MSB side so the result lands in place after STEPS shifts.
  assign d_cat = {slice_diff, d_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        d_d   = d_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
        br_d  = slice_br;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bout_d  = slice_br;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub in three configurations: 8/1, 8/4 and 1/1.
module tb_serial_sub;

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [3];
  logic       iv   [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       ordy [3];
  logic       bi   [3];
  logic       bo   [3];
  logic [7:0] a_s  [3];
  logic [7:0] b_s  [3];
  logic [7:0] d8, d84;
  logic       d1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;

  serial_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8 (
    .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
    .bin(bi[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .d(d8), .bout(bo[0])
  );

  serial_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_w8b4 (
    .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
    .bin(bi[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .d(d84), .bout(bo[1])
  );

  serial_sub #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_w1 (
    .clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2][0]), .b(b_s[2][0]),
    .bin(bi[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .d(d1), .bout(bo[2])
  );

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dget(input int w);
    case (w)
      0:       return d8;
      1:       return d84;
      default: return {7'b0, d1};
    endcase
  endfunction

  // Scoreboard monitors: compare whenever a result is handed off.
  always @(negedge clk) begin
    if (ov[0] && ordy[0]) begin
      if (q0.size() == 0) chk("w8_unexpected_out", {d8, bo[0]}, 9'h1ff ^ {d8, bo[0]});
      else chk("w8_result", {d8, bo[0]}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov[1] && ordy[1]) begin
      if (q1.size() == 0) chk("w8b4_unexpected_out", {d84, bo[1]}, 9'h1ff ^ {d84, bo[1]});
      else chk("w8b4_result", {d84, bo[1]}, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov[2] && ordy[2]) begin
      if (q2.size() == 0) chk("w1_unexpected_out", {7'b0, d1, bo[2]}, 9'h1ff ^ {7'b0, d1, bo[2]});
      else chk("w1_result", {7'b0, d1, bo[2]}, q2.pop_front());
    end
  end

  // Issue one operation and check result latency; called #1 after a rising edge.
  task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                    input logic [7:0] ed, input logic eb, input int steps);
    exp_t e;
    e.d    = ed;
    e.bout = eb;
    case (w)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    chk("ready_before_op", {8'b0, ir[w]}, 9'd1);
    iv[w]  = 1'b1;
    a_s[w] = av;
    b_s[w] = bv;
    bi[w]  = bv_in;
    @(posedge clk);
    #1 iv[w] = 1'b0;
    repeat (steps - 1) @(posedge clk);
    #1 chk("latency_early", {8'b0, ov[w]}, 9'd0);
    @(posedge clk);
    #1 chk("latency_valid", {8'b0, ov[w]}, 9'd1);
  endtask

  task automatic after_handoff(input int w);
    @(posedge clk);
    #1 chk("ready_after_handoff", {7'b0, ir[w], ov[w]}, 9'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; ordy[i] = 1'b1; bi[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready_valid", {7'b0, ir[i], ov[i]}, 9'b10);
      chk("reset_d_bout", {dget(i), bo[i]}, 9'h000);
      rst[i] = 1'b0;
    end

    // WIDTH=8, one bit per cycle
    op(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8);
    after_handoff(0);
    op(0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 8);
    after_handoff(0);
    op(0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8);
    after_handoff(0);

    // Backpressure: result must hold and new offers must be ignored
    ordy[0] = 1'b0;
    op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 8);
    iv[0] = 1'b1; a_s[0] = 8'h33; b_s[0] = 8'h11;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 chk("bp_hold_result", {d8, bo[0]}, {8'h7F, 1'b0});
      chk("bp_hold_flags", {7'b0, ir[0], ov[0]}, 9'b01);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    after_handoff(0);
    chk("d_held_after_handoff", {d8, bo[0]}, {8'h7F, 1'b0});

    // Reset during step 3 discards the operation
    iv[0] = 1'b1; a_s[0] = 8'h55; b_s[0] = 8'h22;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    chk("midrun_reset_flags", {7'b0, ir[0], ov[0]}, 9'b10);
    chk("midrun_reset_d", {d8, bo[0]}, 9'h000);
    op(0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 8);
    after_handoff(0);

    // WIDTH=8, four bits per cycle
    op(1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 2);
    after_handoff(1);
    op(1, 8'h12, 8'h34, 1'b1, 8'hDD, 1'b1, 2);
    after_handoff(1);

    // WIDTH=1: half-subtractor truth table
    op(2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1);
    after_handoff(2);
    op(2, 8'h00, 8'h01, 1'b0, 8'h01, 1'b1, 1);
    after_handoff(2);
    op(2, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1);
    after_handoff(2);
    op(2, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1);
    after_handoff(2);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 9'(q0.size() + q1.size() + q2.size()), 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
